// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the mul/div unit.
// The optional divide-by-zero flag port is selected with MULDIV_DIV0_FLAG_EN.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [2:0] f_op);
        return (f_op == OP_MULT) || (f_op == OP_MULTU) || (f_op == OP_DIV) || (f_op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] f_op);
        return (f_op == OP_MULT) || (f_op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] f_op);
        return (f_op == OP_DIV) || (f_op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns magnitude product / quotient / remainder into final HI/LO values.
// Divide by zero forces an all-ones quotient regardless of operand signs.
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic             i_div0,
    input  logic             i_neg_q,
    input  logic             i_neg_r,
    input  logic [WIDTH-1:0] i_hi_mag,
    input  logic [WIDTH-1:0] i_lo_mag,
    output logic [WIDTH-1:0] o_hi_c,
    output logic [WIDTH-1:0] o_lo_c
);

    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_prod = {i_hi_mag, i_lo_mag};
        o_hi_c = i_hi_mag;
        o_lo_c = i_lo_mag;
        if (!i_is_div) begin
            if (i_neg_q) begin
                w_prod = (2*WIDTH)'(0) - w_prod;
            end
            {o_hi_c, o_lo_c} = w_prod;
        end else begin
            if (i_neg_r) begin
                o_hi_c = WIDTH'(0) - i_hi_mag;
            end
            if (i_div0) begin
                o_lo_c = '1;
            end else if (i_neg_q) begin
                o_lo_c = WIDTH'(0) - i_lo_mag;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit with architectural HI/LO.
// Define MULDIV_DIV0_FLAG_EN to add the div0 port and suppress HI/LO writes on divide by zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic [WIDTH-1:0] lo,
    output logic             div0
`else
    output logic [WIDTH-1:0] lo
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;

    logic             w_is_div;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_mag;
    logic [WIDTH-1:0] w_rt_mag;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_lo_fix;

    // Operand magnitudes for the unsigned datapath; signs are re-applied in FIX.
    assign w_is_div = is_div_op(op);
    assign w_rs_neg = is_signed_op(op) & rs_val[WIDTH-1];
    assign w_rt_neg = is_signed_op(op) & rt_val[WIDTH-1];
    assign w_rs_mag = w_rs_neg ? (WIDTH'(0) - rs_val) : rs_val;
    assign w_rt_mag = w_rt_neg ? (WIDTH'(0) - rt_val) : rt_val;

    // Shift-add step: multiplier sits in r_acc_lo and is consumed LSB first.
    assign w_addend = r_acc_lo[0] ? r_b : '0;
    assign w_sum    = {1'b0, r_acc_hi} + {1'b0, w_addend};

    // Restoring-divide step: borrow out of w_diff means the trial subtract failed.
    assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_b};

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_is_div (r_is_div),
        .i_div0   (r_div0),
        .i_neg_q  (r_neg_q),
        .i_neg_r  (r_neg_r),
        .i_hi_mag (r_acc_hi),
        .i_lo_mag (r_acc_lo),
        .o_hi_c   (w_hi_fix),
        .o_lo_c   (w_lo_fix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div0 <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (is_muldiv(op)) begin
                            r_state  <= CALC;
                            busy     <= 1'b1;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_is_div <= w_is_div;
                            r_acc_hi <= '0;
                            r_acc_lo <= w_is_div ? w_rs_mag : w_rt_mag;
                            r_b      <= w_is_div ? w_rt_mag : w_rs_mag;
                            r_neg_q  <= w_rs_neg ^ w_rt_neg;
                            r_neg_r  <= w_rs_neg;
                            r_div0   <= w_is_div && (rt_val == '0);
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_is_div) begin
                        r_acc_hi <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {w_sum, r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
`ifdef MULDIV_DIV0_FLAG_EN
                    if (r_div0) begin
                        div0 <= 1'b1;
                    end else begin
                        hi <= w_hi_fix;
                        lo <= w_lo_fix;
                    end
`else
                    hi <= w_hi_fix;
                    lo <= w_lo_fix;
`endif
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-by-cycle comparison against a plain-arithmetic
// model, plus hand-computed literal results for the directed vectors.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic             div0;
`endif

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
`ifdef MULDIV_DIV0_FLAG_EN
        .lo     (lo),
        .div0   (div0)
`else
        .lo     (lo)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of a mul/div op as {hi, lo}, straight from the arithmetic rules.
    function automatic logic [63:0] model_res(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = $signed(a);
        sb = $signed(b);
        case (f_op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left;
    logic [63:0] m_pend;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        m_div0;
    logic        m_pend_div0;
`endif

    // Model: an accepted mul/div completes WIDTH+1 edges later; start is ignored while busy.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
`ifdef MULDIV_DIV0_FLAG_EN
            m_div0 = 1'b0;
`endif
        end else begin
            m_done = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            m_div0 = 1'b0;
`endif
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
                    if (m_pend_div0) m_div0 = 1'b1;
                    else {m_hi, m_lo} = m_pend;
`else
                    {m_hi, m_lo} = m_pend;
`endif
                end
            end else if (start) begin
                if (op <= OP_DIVU) begin
                    m_busy = 1'b1;
                    m_left = WIDTH + 1;
                    m_pend = model_res(op, rs_val, rt_val);
`ifdef MULDIV_DIV0_FLAG_EN
                    m_pend_div0 = (op == OP_DIV || op == OP_DIVU) && (rt_val == 32'd0);
`endif
                end else if (op == OP_MTHI) begin
                    m_hi = rs_val;
                end else if (op == OP_MTLO) begin
                    m_lo = rs_val;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 64'(busy), 64'(m_busy));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_hi", 64'(hi), 64'(m_hi));
            check("cyc_lo", 64'(lo), 64'(m_lo));
`ifdef MULDIV_DIV0_FLAG_EN
            check("cyc_div0", 64'(div0), 64'(m_div0));
`endif
        end
    end

    // Issue an op at the current negedge and wait (bounded) for done; optionally keep
    // hammering start with random operands while the op is in flight.
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, output int n, output int bc);
        bit seen;
        op = t_op;
        rs_val = a;
        rt_val = b;
        start = 1'b1;
        n = 0;
        bc = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!hold || n >= 30) begin
                start = 1'b0;
            end else begin
                rs_val = $urandom;
                rt_val = $urandom;
                op = 3'($urandom_range(0, 5));
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            bc += int'(busy);
            n++;
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'd1);
    endtask

    int n_lat;
    int n_busy;
    int n_pulses;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op = OP_MULT;
        rs_val = '0;
        rt_val = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, n_lat, n_busy);
        check("mult_latency", 64'(n_lat), 64'd33);
        check("mult_busy_cycles", 64'(n_busy), 64'd33);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        check("model_mult", model_res(OP_MULT, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n_lat, n_busy);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n_lat, n_busy);
        check("mult_m1_hi", 64'(hi), 64'd0);
        check("mult_m1_lo", 64'(lo), 64'd1);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, n_lat, n_busy);
        check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        check("model_div", model_res(OP_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, n_lat, n_busy);
        check("div_negdiv_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_negdiv_hi", 64'(hi), 64'd1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n_lat, n_busy);
        check("div_ovf_lo", 64'(lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(hi), 64'd0);

        run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, n_lat, n_busy);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div0_flag", 64'(div0), 64'd1);
        check("div0_lo_kept", 64'(lo), 64'h8000_0000);
        check("div0_hi_kept", 64'(hi), 64'd0);
`else
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi), 64'h0000_0064);
`endif

        // Issued during the done cycle of the previous op: must be accepted immediately.
        run_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, n_lat, n_busy);
        check("b2b_latency", 64'(n_lat), 64'd33);
        check("divu_lo", 64'(lo), 64'd142);
        check("divu_hi", 64'(hi), 64'd6);
        run_op(OP_MULTU, 32'd3, 32'd4, 1'b0, n_lat, n_busy);
        check("b2b2_latency", 64'(n_lat), 64'd33);
        check("multu_small_lo", 64'(lo), 64'd12);

        op = OP_MTHI;
        rs_val = 32'h1234_5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo", 64'(lo), 64'd12);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        op = OP_MTLO;
        rs_val = 32'hCAFE_F00D;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo_busy", 64'(busy), 64'd0);

        run_op(OP_MULT, 32'd5, 32'hFFFF_FFFC, 1'b1, n_lat, n_busy);
        check("hold_latency", 64'(n_lat), 64'd33);
        check("hold_hi", 64'(hi), 64'hFFFF_FFFF);
        check("hold_lo", 64'(lo), 64'hFFFF_FFEC);
        @(negedge clk);
        check("hold_no_requeue", 64'(busy), 64'd0);
        check("hold_single_done", 64'(done), 64'd0);

        // Reset during the 10th CALC cycle aborts without a done pulse.
        op = OP_MULT;
        rs_val = 32'd123;
        rt_val = 32'd456;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        n_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_pulses += int'(done);
        end
        check("abort_no_done", 64'(n_pulses), 64'd0);
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, n_lat, n_busy);
        check("post_rst_lo", 64'(lo), 64'd42);
        check("post_rst_hi", 64'(hi), 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using a radix-2 shift-add / restoring-divide datapath. A start/busy/done handshake lets the main control FSM stall MFHI/MFLO and new mul/div ops while an operation is in flight. It sits beside the ALU, fed from the A/B operand registers; HI/LO feed the register write-back mux.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk      input   1      clock, rising edge
rst_n    input   1      synchronous reset, active-low
start    input   1      request; sampled only when busy=0
op       input   3      operation code (package constants)
rs_val   input   WIDTH  dividend / multiplicand / MTHI-MTLO source
rt_val   input   WIDTH  divisor / multiplier
busy     output  1      operation in flight; start ignored
done     output  1      one-cycle pulse: HI/LO just updated by mul/div
hi       output  WIDTH  HI register
lo       output  WIDTH  LO register

Behaviour:
- Reset: one clk; reset is synchronous and active-low (rst_n sampled on rising clk). rst_n=0 forces state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Mid-operation reset aborts with no done pulse.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU latches operand magnitudes (signed ops take two's-complement abs), records result signs, counter=WIDTH, goes to CALC, busy=1 from next cycle.
  - start=1 with MTHI: hi<=rs_val next edge. MTLO: lo<=rs_val. Stays IDLE, no busy, no done.
  - Undefined op code: ignored.
- CALC: one quotient/product bit per cycle; counter decrements; counter reaching 1 transitions to FIX.
- FIX: applies sign correction; writes hi/lo; goes to IDLE. On that edge busy<=0 and done<=1 for exactly one cycle.
- Latency: start accepted at edge E0 -> hi/lo valid and done=1 after edge E0+WIDTH+1; busy high for WIDTH+1 cycles.
- Multiply results: {hi,lo} = full 2*WIDTH-bit product; signed for MULT, unsigned for MULTU.
- Divide results: lo=quotient truncated toward zero; hi=remainder with the dividend's sign.
- Overflow case: DIV of most-negative by -1 gives lo=most-negative, hi=0.
- Divide by zero, default build: lo=all ones, hi=rs_val unchanged; no flag.
- start while busy: ignored; no queueing. op/rs_val/rt_val may change after acceptance.
- start on the same cycle done is high: accepted, since busy=0 then.

Optional Feature:
MULDIV_DIV0_FLAG_EN:
- Defined: adds output port div0 (1 bit, reset 0). On divide by zero, div0 pulses together with done, and hi/lo are left unchanged (no write).
- Undefined: no div0 port; divide-by-zero result as in Behaviour.

Decomposition:
- Package muldiv_pkg holds:
  - op codes: OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5
  - FSM state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2
- Sub-module muldiv_sign_fix: combinational; takes magnitude product/quotient/remainder and sign flags and produces the final hi/lo. Instantiated once, used in FIX.

Test Plan (WIDTH=32):
- MULT rs=0xFFFFFFFD (-3), rt=7 -> done exactly 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT on same operands -> hi=0, lo=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0:
  - Default build -> lo=0xFFFFFFFF, hi=0x00000064.
  - With MULDIV_DIV0_FLAG_EN -> div0=1 with done; hi/lo keep prior values.
- MTHI 0x12345678 while idle -> hi updated next edge; busy and done stay 0. Then a MULT start re-asserted every cycle while busy -> only the first is accepted; one done pulse; result matches the first operands.
- rst_n=0 on the 10th CALC cycle -> next edge busy=0, hi=lo=0, done never pulses. A new MULTU 6*7 afterwards -> lo=42, hi=0.
